if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage with the IF/ID pipeline register.
- Holds the fetch PC and runs a request/ready handshake to instruction memory.
- Captures the returned word into the IF/ID latch for decode.
- Sits directly upstream of the next-PC unit: it supplies pc4_D to that unit and consumes next_pc/if_jump from it to pick the following fetch address.
- Also applies CP0 redirects (exception entry, eret) and hazard-unit stalls.

Parameters:
RESET_PC, 32'h00003000, fetch PC loaded on reset
EXC_PC, 32'h00004180, exception handler entry
NOP_WORD, 32'h00000000, word inserted into IF/ID on flush/bubble

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
stall  in  1  hazard-unit stall (already includes fetch_busy); freezes pc_F and IF/ID
next_pc  in  32  target from next-PC unit
if_jump  in  1  1 = instruction in D redirects; next_pc valid
exc_req  in  1  CP0 exception taken this cycle
eret_req  in  1  eret in D/E committing this cycle
epc  in  32  CP0 EPC
imem_addr  out  32  fetch address (= pc_F, or held address in KILL)
imem_req  out  1  fetch request
imem_rdata  in  32  instruction word, valid when imem_ready
imem_ready  in  1  response strobe for current request
fetch_busy  out  1  request outstanding, no data this cycle
instr_D  out  32  IF/ID instruction
pc_D  out  32  IF/ID PC
pc4_D  out  32  pc_D + 4, fed to next-PC unit
bd_D  out  1  instruction in D is a branch delay slot
excode_D  out  5  fetch exception code

Behaviour:
- Reset (reset==0 at edge):
  - pc_F=RESET_PC, state=WAIT, hold buffer cleared.
  - instr_D=NOP_WORD, pc_D=0, pc4_D=0, bd_D=0, excode_D=0.
  - imem_req=0 while reset low.
  - Reset mid-request abandons it; memory must tolerate this.
- States WAIT, HOLD, KILL.
- Memory protocol:
  - imem_req level-high; imem_addr stable until imem_ready.
  - Latency >=1 cycle; one outstanding request max.
- Sequential PC: seq = if_jump ? next_pc : pc_F+4 (32-bit wrap, carry dropped).
- Advance: IF/ID loads instr_D=word, pc_D=pc_F, pc4_D=pc_F+4, bd_D=if_jump, excode_D=0; pc_F<=seq.
- WAIT:
  - imem_req=1; fetch_busy = !imem_ready.
  - ready & !stall: advance; stay WAIT, new request next cycle.
  - ready & stall: word into hold buffer; -> HOLD.
  - !ready: IF/ID and pc_F hold.
- HOLD:
  - imem_req=0, fetch_busy=0.
  - !stall: advance using buffer; -> WAIT.
- KILL:
  - imem_req=1 on saved old address; fetch_busy=1.
  - On ready: discard data; -> WAIT on pc_F.
- Redirect priority: reset > exc_req > eret_req > normal. Redirects override stall.
  - exc_req: pc_F<=EXC_PC. eret_req: pc_F<=epc.
  - IF/ID <= NOP_WORD, bd_D=0, excode_D=0.
  - From WAIT with !ready: -> KILL, saving old address.
  - From WAIT with ready, or from HOLD: data/buffer dropped; -> WAIT.
  - In KILL: pc_F retargeted, stay KILL.
- stall only freezes; it never flushes.
- if_jump is sampled only on an advance cycle.

Optional Feature:
FETCH_ADEL_EN
- Defined, WAIT with pc_F[1:0]!=0:
  - imem_req=0.
  - Treated as an immediate response: instr_D=NOP_WORD, excode_D=5'd4 (AdEL), pc_D=faulting pc_F.
  - stall, advance, HOLD and redirect rules as for a normal response.
- Undefined: excode_D tied to 0; imem_addr[1:0] driven but ignored.

Test Plan:
1. Release reset, ready 1 cycle after each req, words 0x24010001.. -> imem_addr 0x3000,0x3004,0x3008; instr_D follows 1 cycle after ready; pc4_D=0x3004 with first word.
2. if_jump=1, next_pc=0x3100 during fetch of 0x3008 (delay slot) -> bd_D=1 for 0x3008; next imem_addr=0x3100, bd_D=0 on it.
3. stall=1 for 3 cycles at ready -> HOLD, imem_req=0, IF/ID unchanged; after release, buffered word in instr_D, next addr pc+4.
4. exc_req while request to 0x3010 pending (ready after 3 cycles) -> KILL, stale word never in instr_D; next request 0x4180; instr_D=NOP_WORD, bd_D=0.
5. eret_req, epc=0x3024, with stall=1 -> flush wins; next fetch at 0x3024.
6. With FETCH_ADEL_EN, jump to next_pc=0x3102 -> no req; instr_D=0, excode_D=4, pc_D=0x3102; without macro, req issued to 0x3102, excode_D=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Holds the fetch PC,
//   runs a level-high request/ready handshake to instruction memory, loads the
//   returned word into IF/ID, and applies CP0 redirects (exception, eret) and
//   hazard stalls. Feeds pc4_D to the next-PC unit and takes next_pc/if_jump
//   back to choose the following fetch address.
//
//   Optional feature macro: FETCH_ADEL_EN
//     When defined, a misaligned fetch PC (pc_F[1:0] != 0) issues no memory
//     request and instead completes immediately with NOP_WORD and excode 4.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   stall               : freeze pc_F and IF/ID (never flushes)
//   next_pc, if_jump    : redirect target / take it, from the next-PC unit
//   exc_req, eret_req   : CP0 redirects (to EXC_PC / to epc)
//   epc                 : CP0 EPC
//   imem_addr/req       : fetch request to instruction memory
//   imem_rdata/ready    : memory response
//   fetch_busy          : request outstanding with no data this cycle
//   instr_D, pc_D, pc4_D, bd_D, excode_D : IF/ID register contents
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] next_pc,
    input  logic        if_jump,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        fetch_busy,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        bd_D,
    output logic [4:0]  excode_D
);

    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_KILL} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_F, pc_F_nx;
    logic [31:0] kill_addr, kill_addr_nx;   // address of the abandoned request
    logic [31:0] hold_word, hold_word_nx;   // response captured while stalled
    logic [4:0]  hold_exc, hold_exc_nx;
    logic [31:0] instr_nx, pc_D_nx, pc4_D_nx;
    logic        bd_nx;
    logic [4:0]  excode_nx;

    logic        adel;
    logic        resp;
    logic [31:0] resp_word;
    logic [4:0]  resp_exc;
    logic        redirect;
    logic [31:0] redir_pc;
    logic        adv;
    logic [31:0] adv_word;
    logic [4:0]  adv_exc;

`ifdef FETCH_ADEL_EN
    assign adel = (state == S_WAIT) && (pc_F[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    // A misaligned fetch behaves exactly like a memory response arriving now.
    assign resp      = (state == S_WAIT) && (adel || imem_ready);
    assign resp_word = adel ? NOP_WORD : imem_rdata;
    assign resp_exc  = adel ? 5'd4 : 5'd0;
    assign redirect  = exc_req || eret_req;
    assign redir_pc  = exc_req ? EXC_PC : epc;

    // State and IF/ID registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_WAIT;
            pc_F      <= RESET_PC;
            kill_addr <= 32'd0;
            hold_word <= 32'd0;
            hold_exc  <= 5'd0;
            instr_D   <= NOP_WORD;
            pc_D      <= 32'd0;
            pc4_D     <= 32'd0;
            bd_D      <= 1'b0;
            excode_D  <= 5'd0;
        end else begin
            state     <= state_nx;
            pc_F      <= pc_F_nx;
            kill_addr <= kill_addr_nx;
            hold_word <= hold_word_nx;
            hold_exc  <= hold_exc_nx;
            instr_D   <= instr_nx;
            pc_D      <= pc_D_nx;
            pc4_D     <= pc4_D_nx;
            bd_D      <= bd_nx;
            excode_D  <= excode_nx;
        end
    end

    // Next-state / next-register logic
    always_comb begin
        state_nx     = state;
        pc_F_nx      = pc_F;
        kill_addr_nx = kill_addr;
        hold_word_nx = hold_word;
        hold_exc_nx  = hold_exc;
        instr_nx     = instr_D;
        pc_D_nx      = pc_D;
        pc4_D_nx     = pc4_D;
        bd_nx        = bd_D;
        excode_nx    = excode_D;
        adv          = 1'b0;
        adv_word     = resp_word;
        adv_exc      = resp_exc;

        case (state)
            S_WAIT: begin
                if (redirect) begin
                    // Data arriving now is dropped; otherwise the in-flight
                    // request must still be drained on its original address.
                    if (!resp) begin
                        state_nx     = S_KILL;
                        kill_addr_nx = pc_F;
                    end
                end else if (resp) begin
                    if (!stall) begin
                        adv = 1'b1;
                    end else begin
                        hold_word_nx = resp_word;
                        hold_exc_nx  = resp_exc;
                        state_nx     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_nx = S_WAIT;
                end else if (!stall) begin
                    adv      = 1'b1;
                    adv_word = hold_word;
                    adv_exc  = hold_exc;
                    state_nx = S_WAIT;
                end
            end
            S_KILL: begin
                // The stale response is discarded; a redirect arriving in the
                // same cycle only retargets pc_F.
                if (imem_ready)
                    state_nx = S_WAIT;
            end
            default: state_nx = S_WAIT;
        endcase

        if (redirect) begin
            pc_F_nx   = redir_pc;
            instr_nx  = NOP_WORD;
            bd_nx     = 1'b0;
            excode_nx = 5'd0;
        end else if (adv) begin
            instr_nx  = adv_word;
            pc_D_nx   = pc_F;
            pc4_D_nx  = pc_F + 32'd4;
            bd_nx     = if_jump;
            excode_nx = adv_exc;
            pc_F_nx   = if_jump ? next_pc : pc_F + 32'd4;
        end
    end

    // Memory-side outputs
    always_comb begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        imem_addr  = pc_F;
        case (state)
            S_WAIT: begin
                imem_req   = reset && !adel;
                fetch_busy = reset && !adel && !imem_ready;
            end
            S_KILL: begin
                imem_addr  = kill_addr;
                imem_req   = reset;
                fetch_busy = reset;
            end
            default: ;
        endcase
    end

endmodule
